// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Result and overflow flag are held between completions for the digit scan path.
module bin_to_bcd_seq #(
    parameter int unsigned WIDTH  = 14,
    parameter int unsigned DIGITS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [WIDTH-1:0]      i_bin,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_ovf
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    // Largest displayable value (10^DIGITS - 1) truncated to the input width
    function automatic logic [WIDTH-1:0] max_disp();
        longint unsigned p;
        p = 1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            p = p * 10;
        end
        return WIDTH'(p - 1);
    endfunction

    localparam logic [WIDTH-1:0] MAX_VAL = max_disp();

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   shreg;
    logic [BCD_W-1:0]   scratch;
    logic [CNT_W-1:0]   cnt;
    logic               ovf_flag;
    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   shifted;

    // Add-3 correction per nibble, then the scratch half of the left shift
    always_comb begin
        adj = scratch;
        for (int unsigned d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
            end
        end
        shifted = {adj[BCD_W-2:0], shreg[WIDTH-1]};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_bcd    <= '0;
            o_ovf    <= 1'b0;
            shreg    <= '0;
            scratch  <= '0;
            cnt      <= '0;
            ovf_flag <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        shreg    <= i_bin;
                        scratch  <= '0;
                        cnt      <= CNT_W'(WIDTH);
                        ovf_flag <= (i_bin > MAX_VAL);
                        o_busy   <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= shifted;
                    shreg   <= {shreg[WIDTH-2:0], 1'b0};
                    cnt     <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        o_bcd  <= ovf_flag ? {DIGITS{4'h9}} : shifted;
                        o_ovf  <= ovf_flag;
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
